cb_bitop_seq: RTL and testbench
===============================

Name: cb_bitop_seq

Overview:
- Sequencer for the CB-prefixed BIT/RES/SET instructions; drives the shared ALU bit-op path, the register file port and the memory bus.
- Accepts a decoded CB opcode byte from the instruction decoder and runs the M-cycle schedule: register operand or (HL) read-modify-write.
- The ALU stays external: this block drives its function/operand inputs and captures its result.

Parameters:
- MCYC, 4, T-cycles (clocks) per M-cycle; legal values 2..8.
- MEM_WAIT_MAX, 15, clocks a bus M-cycle may stall at its last T-cycle for mem_ack before aborting.

Ports:
- clk  in  1  system clock; one T-cycle per rising edge
- nreset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- opcode  in  8  CB opcode: [7:6] op (01 BIT, 10 RES, 11 SET, 00 illegal), [5:3] bit index, [2:0] reg (6 = (HL))
- hl  in  16  current HL value, sampled with start
- busy  out  1  high from the clock after acceptance until done
- done  out  1  one-clock completion pulse
- err  out  1  one-clock pulse with done on illegal opcode or bus timeout
- reg_sel  out  3  register index, held while busy
- reg_rdata  in  8  register file read data
- reg_we  out  1  one-clock write strobe
- reg_wdata  out  8  write data
- mem_addr  out  16  bus address
- mem_rd  out  1  read request
- mem_wr  out  1  write request
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid with mem_ack
- mem_ack  in  1  bus handshake
- alu_fn  out  2  00 none, 01 BIT, 10 RES, 11 SET
- alu_a  out  8  ALU operand byte (latched)
- alu_b  out  3  bit index
- alu_result  in  8  ALU result, combinational from alu_fn/alu_a/alu_b
- alu_zf  in  1  ALU zero flag for BIT
- flag_we  out  1  one-clock flag update strobe
- flag_z, flag_n, flag_h  out  1 each  flag values; C is never touched

Behaviour:
- Reset: every output 0. FSM returns to IDLE immediately, including mid-operation. A pending read or write is dropped; no strobe is issued afterwards.
- States: IDLE, REG, MRD, MWR, FIN. T-counter tc runs 0..MCYC-1 per M-cycle.
- IDLE: start=1 latches opcode and hl. Next state is REG, MRD (reg=6), or FIN with err (op=00). start while busy is ignored.
- REG: one M-cycle.
  - reg_sel = opcode[2:0] throughout.
  - alu_a latched from reg_rdata at tc=0.
  - At tc=MCYC-1: RES/SET pulse reg_we with reg_wdata=alu_result; BIT pulses flag_we. done pulses in the same clock.
  - Latency from start acceptance to done: MCYC clocks.
- MRD:
  - mem_addr = latched hl.
  - mem_rd is high from tc=0 until the clock mem_ack is sampled high at or after tc=MCYC-1.
  - tc holds at MCYC-1 while waiting; an ack seen earlier is ignored.
  - alu_a is latched from mem_rdata on the accepted ack.
  - BIT: flag_we and done pulse in that clock.
  - RES/SET: go to MWR.
- MWR:
  - mem_wr is high with mem_wdata = alu_result, which is latched at MWR entry and stable for the whole M-cycle.
  - Completion uses the same ack rule as MRD; done pulses on the accepted ack.
- Flags for BIT: flag_z = alu_zf, flag_n = 0, flag_h = 1. RES/SET never pulse flag_we.
- Timeout: if the wait at tc=MCYC-1 exceeds MEM_WAIT_MAX clocks, the block drops mem_rd/mem_wr and pulses done+err. It writes no register, memory or flags.
- busy falls the clock after done. A new start is accepted in the clock busy is low; back-to-back gap is one clock.
- alu_fn is nonzero only while busy; alu_b = opcode[5:3].

Test Plan (MCYC=4):
1. SET 3,B: opcode 0xD8, B=0x00 -> reg_sel=0, reg_we+done at clock 4 after accept, reg_wdata=0x08, no flag_we.
2. RES 7,A: opcode 0xBF, A=0xFF -> reg_sel=7, reg_wdata=0x7F at clock 4; flags untouched.
3. BIT 0,C: opcode 0x41, C=0x5A -> flag_we at clock 4 with z=1, n=0, h=1; no reg_we. Repeat with C=0x5B -> z=0.
4. SET 7,(HL): opcode 0xFE, hl=0xC000, mem returns 0x5A with ack at tc=3 -> mem_rd clocks 1-4 at 0xC000; mem_wr clocks 5-8 with 0xDA; done at clock 8.
5. RES 0,(HL): opcode 0x86, read ack delayed 3 clocks past tc=3, data 0x5B -> MRD lasts 7 clocks, mem_wdata=0x5A, done at clock 11. Second run with ack never asserted -> done+err after 4+15 clocks, no mem_wr.
6. Boundaries:
   - opcode 0x06 (op=00) -> done+err next clock, no strobes.
   - nreset low during MWR -> mem_wr/busy drop immediately; no done.
   - start while busy -> ignored.

Source files
------------

// File: rtl/cb_bitop_seq.sv
// rtl/cb_bitop_seq.sv - CB-prefix BIT/RES/SET sequencer driving external ALU, register file and memory bus
module cb_bitop_seq #(
  parameter int MCYC         = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [15:0] hl,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  reg_sel,
  input  logic [7:0]  reg_rdata,
  output logic        reg_we,
  output logic [7:0]  reg_wdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  alu_fn,
  output logic [7:0]  alu_a,
  output logic [2:0]  alu_b,
  input  logic [7:0]  alu_result,
  input  logic        alu_zf,
  output logic        flag_we,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_h
);

  localparam int TCW = $clog2(MCYC);
  localparam int WCW = $clog2(MEM_WAIT_MAX + 2);
  localparam logic [TCW-1:0] TC_LAST = TCW'(MCYC - 1);
  localparam logic [WCW-1:0] WC_MAX  = WCW'(MEM_WAIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REG  = 3'd1,
    S_MRD  = 3'd2,
    S_MWR  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t         state, state_n;
  logic [TCW-1:0] tc, tc_n;
  logic [WCW-1:0] wc, wc_n;
  logic [7:0]     op_q;
  logic [15:0]    hl_q;
  logic [7:0]     alu_a_q;
  logic [7:0]     wdata_q;
  logic           ld_a_reg, ld_a_mem, ld_wd;

  logic [1:0] op;
  logic       is_bit;
  logic       tc_last;

  assign op      = op_q[7:6];
  assign is_bit  = (op == 2'b01);
  assign tc_last = (tc == TC_LAST);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= S_IDLE;
      tc      <= '0;
      wc      <= '0;
      op_q    <= '0;
      hl_q    <= '0;
      alu_a_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      tc    <= tc_n;
      wc    <= wc_n;
      if (state == S_IDLE && start) begin
        op_q <= opcode;
        hl_q <= hl;
      end
      if (ld_a_reg) alu_a_q <= reg_rdata;
      if (ld_a_mem) alu_a_q <= mem_rdata;
      if (ld_wd)    wdata_q <= alu_result;
    end
  end

  always_comb begin
    state_n   = state;
    tc_n      = tc;
    wc_n      = wc;
    ld_a_reg  = 1'b0;
    ld_a_mem  = 1'b0;
    ld_wd     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    reg_sel   = 3'd0;
    reg_we    = 1'b0;
    reg_wdata = 8'd0;
    mem_addr  = 16'd0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'd0;
    alu_fn    = 2'd0;
    alu_a     = alu_a_q;
    alu_b     = 3'd0;
    flag_we   = 1'b0;
    flag_z    = 1'b0;
    flag_n    = 1'b0;
    flag_h    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          tc_n = '0;
          wc_n = '0;
          if (opcode[7:6] == 2'b00)      state_n = S_FIN;
          else if (opcode[2:0] == 3'd6)  state_n = S_MRD;
          else                           state_n = S_REG;
        end
      end

      S_REG: begin
        busy    = 1'b1;
        reg_sel = op_q[2:0];
        alu_fn  = op;
        alu_b   = op_q[5:3];
        tc_n    = tc + TCW'(1);
        if (tc == '0) ld_a_reg = 1'b1;
        if (tc_last) begin
          done    = 1'b1;
          state_n = S_IDLE;
          tc_n    = '0;
          if (is_bit) begin
            flag_we = 1'b1;
            flag_z  = alu_zf;
            flag_h  = 1'b1;
          end else begin
            reg_we    = 1'b1;
            reg_wdata = alu_result;
          end
        end
      end

      S_MRD: begin
        busy     = 1'b1;
        reg_sel  = op_q[2:0];
        alu_fn   = op;
        alu_b    = op_q[5:3];
        // BIT (HL) sets flags in the ack clock, so the ALU sees read data directly.
        alu_a    = mem_rdata;
        mem_addr = hl_q;
        mem_rd   = 1'b1;
        if (!tc_last) begin
          tc_n = tc + TCW'(1);
        end else if (mem_ack) begin
          ld_a_mem = 1'b1;
          if (is_bit) begin
            flag_we = 1'b1;
            flag_z  = alu_zf;
            flag_h  = 1'b1;
            done    = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_MWR;
          end
          tc_n = '0;
          wc_n = '0;
        end else if (wc == WC_MAX) begin
          state_n = S_FIN;
        end else begin
          wc_n = wc + WCW'(1);
        end
      end

      S_MWR: begin
        busy     = 1'b1;
        reg_sel  = op_q[2:0];
        alu_fn   = op;
        alu_b    = op_q[5:3];
        mem_addr = hl_q;
        mem_wr   = 1'b1;
        // tc==0 occurs once per write cycle; the registered copy covers the rest.
        if (tc == '0) begin
          ld_wd     = 1'b1;
          mem_wdata = alu_result;
        end else begin
          mem_wdata = wdata_q;
        end
        if (!tc_last) begin
          tc_n = tc + TCW'(1);
        end else if (mem_ack) begin
          done    = 1'b1;
          state_n = S_IDLE;
          tc_n    = '0;
          wc_n    = '0;
        end else if (wc == WC_MAX) begin
          state_n = S_FIN;
        end else begin
          wc_n = wc + WCW'(1);
        end
      end

      S_FIN: begin
        busy    = 1'b1;
        reg_sel = op_q[2:0];
        done    = 1'b1;
        err     = 1'b1;
        state_n = S_IDLE;
        tc_n    = '0;
        wc_n    = '0;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cb_bitop_seq.sv
// tb/tb_cb_bitop_seq.sv - scoreboard bench for cb_bitop_seq with register file, memory and ALU models
module tb_cb_bitop_seq;

  logic        clk;
  logic        nreset;
  logic        start;
  logic [7:0]  opcode;
  logic [15:0] hl;
  logic        busy, done, err;
  logic [2:0]  reg_sel;
  logic [7:0]  reg_rdata;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [1:0]  alu_fn;
  logic [7:0]  alu_a;
  logic [2:0]  alu_b;
  logic [7:0]  alu_result;
  logic        alu_zf;
  logic        flag_we, flag_z, flag_n, flag_h;

  cb_bitop_seq #(.MCYC(4), .MEM_WAIT_MAX(15)) dut (
    .clk(clk), .nreset(nreset), .start(start), .opcode(opcode), .hl(hl),
    .busy(busy), .done(done), .err(err),
    .reg_sel(reg_sel), .reg_rdata(reg_rdata), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zf(alu_zf),
    .flag_we(flag_we), .flag_z(flag_z), .flag_n(flag_n), .flag_h(flag_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Register file, ALU and memory models
  logic [7:0] regs [8];
  assign reg_rdata = regs[reg_sel];

  always_comb begin
    alu_result = 8'h00;
    alu_zf     = ~alu_a[alu_b];
    case (alu_fn)
      2'b01:   alu_result = alu_a;
      2'b10:   alu_result = alu_a & ~(8'h01 << alu_b);
      2'b11:   alu_result = alu_a | (8'h01 << alu_b);
      default: alu_result = 8'h00;
    endcase
  end

  int   mcnt = 0;
  int   rd_dly = 0;
  int   wr_dly = 0;
  bit   early = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic req;
  assign req       = mem_rd | mem_wr;
  assign mem_rdata = rd_data;

  always_comb begin
    int dly;
    dly     = mem_wr ? wr_dly : rd_dly;
    mem_ack = req && (((dly >= 0) && (mcnt == 3 + dly)) || (early && mcnt == 1));
  end

  always @(posedge clk) begin
    if (!req || (mem_ack && mcnt >= 3)) mcnt <= 0;
    else                                mcnt <= mcnt + 1;
  end

  typedef struct {
    int          t;
    bit          er;
    logic [2:0]  rsel;
    bit          rwe;
    logic [7:0]  rwd;
    bit          fwe;
    bit          z;
    int          rd_n;
    int          rd_first;
    int          wr_n;
    int          wr_first;
    logic [7:0]  wd;
    logic [15:0] addr;
  } exp_t;

  exp_t q[$];

  // Monitor: accumulates bus activity per operation and scores it at done
  int          a_rd_n = 0, a_rd_first = 0, a_wr_n = 0, a_wr_first = 0;
  logic [7:0]  a_wd_first = 0, a_wd_last = 0;
  logic [15:0] a_addr = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!nreset) begin
      a_rd_n = 0;
      a_wr_n = 0;
    end else begin
      if (mem_rd) begin
        if (a_rd_n == 0) a_rd_first = tick;
        a_rd_n++;
        a_addr = mem_addr;
      end
      if (mem_wr) begin
        if (a_wr_n == 0) begin
          a_wr_first = tick;
          a_wd_first = mem_wdata;
        end
        a_wr_n++;
        a_wd_last = mem_wdata;
        a_addr    = mem_addr;
      end
      if (!done && (reg_we || flag_we)) chk("stray_strobe", {reg_we, flag_we}, 2'b00);
      if (!busy && alu_fn != 2'b00) chk("alu_fn_idle", alu_fn, 2'b00);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          e = q.pop_front();
          chk("done_time", tick, e.t);
          chk("err", err, e.er);
          chk("reg_sel", reg_sel, e.rsel);
          chk("reg_we", reg_we, e.rwe);
          if (e.rwe) chk("reg_wdata", reg_wdata, e.rwd);
          chk("flag_we", flag_we, e.fwe);
          if (e.fwe) chk("flags_znh", {flag_z, flag_n, flag_h}, {e.z, 1'b0, 1'b1});
          chk("rd_cycles", a_rd_n, e.rd_n);
          if (e.rd_n > 0) begin
            chk("rd_first", a_rd_first, e.rd_first);
            chk("mem_addr", a_addr, e.addr);
          end
          chk("wr_cycles", a_wr_n, e.wr_n);
          if (e.wr_n > 0) begin
            chk("wr_first", a_wr_first, e.wr_first);
            chk("wdata_first", a_wd_first, e.wd);
            chk("wdata_last", a_wd_last, e.wd);
          end
        end
        a_rd_n = 0;
        a_wr_n = 0;
      end
    end
  end

  task automatic issue(input logic [7:0] opc, input logic [15:0] h, input bit push,
                       input int dn, input bit er, input bit rwe, input logic [7:0] rwd,
                       input bit fwe, input bit z, input int rdn, input int wrn,
                       input logic [7:0] wd);
    exp_t e;
    @(negedge clk);
    e.t = tick + dn;
    e.er = er;
    e.rsel = opc[2:0];
    e.rwe = rwe;
    e.rwd = rwd;
    e.fwe = fwe;
    e.z = z;
    e.rd_n = rdn;
    e.rd_first = tick + 1;
    e.wr_n = wrn;
    e.wr_first = tick + rdn + 1;
    e.wd = wd;
    e.addr = h;
    if (push) q.push_back(e);
    start  = 1'b1;
    opcode = opc;
    hl     = h;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    int n;
    nreset = 1'b0;
    start  = 1'b0;
    opcode = 8'h00;
    hl     = 16'h0000;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {busy, done, err, reg_sel, reg_we, reg_wdata, mem_addr, mem_rd, mem_wr, mem_wdata,
         alu_fn, alu_a, alu_b, flag_we, flag_z, flag_n, flag_h}, 64'd0);
    nreset = 1'b1;

    // SET 3,B
    regs[0] = 8'h00;
    issue(8'hD8, 16'h0000, 1, 4, 0, 1, 8'h08, 0, 0, 0, 0, 8'h00);
    wait_done();
    // RES 7,A
    regs[7] = 8'hFF;
    issue(8'hBF, 16'h0000, 1, 4, 0, 1, 8'h7F, 0, 0, 0, 0, 8'h00);
    wait_done();
    // BIT 0,C with bit clear then set
    regs[1] = 8'h5A;
    issue(8'h41, 16'h0000, 1, 4, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00);
    wait_done();
    regs[1] = 8'h5B;
    issue(8'h41, 16'h0000, 1, 4, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00);
    wait_done();

    // SET 7,(HL), prompt acks
    rd_data = 8'h5A; rd_dly = 0; wr_dly = 0; early = 0;
    issue(8'hFE, 16'hC000, 1, 8, 0, 0, 8'h00, 0, 0, 4, 4, 8'hDA);
    wait_done();
    // RES 0,(HL), read ack 3 late plus an early ack to be ignored
    rd_data = 8'h5B; rd_dly = 3; wr_dly = 0; early = 1;
    issue(8'h86, 16'h1234, 1, 11, 0, 0, 8'h00, 0, 0, 7, 4, 8'h5A);
    wait_done();
    // RES 0,(HL), no ack: timeout
    rd_dly = -1; early = 0;
    issue(8'h86, 16'h1234, 1, 20, 1, 0, 8'h00, 0, 0, 19, 0, 8'h00);
    wait_done();

    // BIT 4,(HL): flags set in the read ack clock
    rd_data = 8'h10; rd_dly = 1;
    issue(8'h66, 16'h00AA, 1, 5, 0, 0, 8'h00, 1, 0, 5, 0, 8'h00);
    wait_done();

    // Illegal op
    issue(8'h06, 16'h0000, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    wait_done();

    // start while busy is ignored
    regs[0] = 8'h10;
    issue(8'hD8, 16'h0000, 1, 4, 0, 1, 8'h18, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    start = 1'b1;
    opcode = 8'hC7;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (8) @(posedge clk);

    // Reset during MWR
    rd_data = 8'h00; rd_dly = 0; wr_dly = -1;
    issue(8'hFE, 16'h8000, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    n = 0;
    while (!mem_wr && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_mwr", mem_wr, 1'b1);
    nreset = 1'b0;
    #1 chk("reset_mid_mwr", {mem_wr, busy, done}, 3'b000);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (8) @(posedge clk);

    // Recovery after reset
    wr_dly = 0;
    regs[2] = 8'h81;
    issue(8'h92, 16'h0000, 1, 4, 0, 1, 8'h81, 0, 0, 0, 0, 8'h00);
    wait_done();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
